div_sequencer: RTL and testbench

Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) that computes its result by sequencing the shared execute-stage ALU through 32 restoring-division steps instead of using a dedicated subtractor. It sits beside the execute stage: while it runs, it owns the ALU control pins (opsel/sub/unsigned/arith) and operands through the execute operand mux, and the pipeline stalls on `o_busy`. Divide-by-zero and signed overflow take a single-cycle fast path.

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/div_sign_fix.sv | 16 +
 rtl/div_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage definitions: ALU opsel encodings, M-extension
// divide func3 codes and the divide sequencer state type.
package rv32_pkg;

    // ALU operation select encodings driven onto the shared execute ALU.
    localparam logic [2:0] ALU_OPSEL_ADD  = 3'b000;
    localparam logic [2:0] ALU_OPSEL_SLL  = 3'b001;
    localparam logic [2:0] ALU_OPSEL_SLT  = 3'b010;
    localparam logic [2:0] ALU_OPSEL_SLTU = 3'b011;
    localparam logic [2:0] ALU_OPSEL_XOR  = 3'b100;
    localparam logic [2:0] ALU_OPSEL_SR   = 3'b101;
    localparam logic [2:0] ALU_OPSEL_OR   = 3'b110;
    localparam logic [2:0] ALU_OPSEL_AND  = 3'b111;

    // RV32M divide/remainder func3 codes.
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation, used for operand magnitudes on
// accept and for restoring result signs after the iterations.
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    // Negate when requested, otherwise pass through.
    always_comb begin
        result = neg ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide unit that borrows the execute-stage ALU for 32
// restoring-division steps. Divide-by-zero and signed overflow finish in a
// single cycle without touching the ALU.
module div_sequencer
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy,
    output logic            o_alu_req,
    output logic [2:0]      o_alu_opsel,
    output logic            o_alu_sub,
    output logic            o_alu_unsigned,
    output logic            o_alu_arith,
    output logic [XLEN-1:0] o_alu_op1,
    output logic [XLEN-1:0] o_alu_op2,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_alu_slt
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state_q, state_d;

    logic             is_signed_q, is_rem_q;
    logic             neg_q_q, neg_r_q;
    logic [XLEN-1:0]  rem_q, quo_q, dsr_q, result_q;
    logic [CNT_W-1:0] cnt_q;

    // Request decode: full func3 compare keeps non-divide codes from
    // being mistaken for signed or remainder operations.
    logic is_signed_in, is_rem_in;
    logic div_zero, sgn_ovf, fast, accept;
    logic [XLEN-1:0] op1_mag, op2_mag, fast_result;

    assign is_signed_in = (i_func3 == F3_DIV) || (i_func3 == F3_REM);
    assign is_rem_in    = (i_func3 == F3_REM) || (i_func3 == F3_REMU);
    assign div_zero     = (i_op2 == '0);
    assign sgn_ovf      = is_signed_in && (i_op1 == INT_MIN) && (&i_op2);
    assign fast         = div_zero || sgn_ovf;
    assign accept       = i_valid && (state_q == IDLE) && !i_flush;

    // Divide-by-zero returns all ones / the dividend; overflow returns
    // INT_MIN (which equals the dividend) / zero.
    assign fast_result = div_zero ? (is_rem_in ? i_op1 : '1)
                                  : (is_rem_in ? '0 : i_op1);

    div_sign_fix #(.W(XLEN)) u_abs_op1 (
        .value  (i_op1),
        .neg    (is_signed_in && i_op1[XLEN-1]),
        .result (op1_mag)
    );

    div_sign_fix #(.W(XLEN)) u_abs_op2 (
        .value  (i_op2),
        .neg    (is_signed_in && i_op2[XLEN-1]),
        .result (op2_mag)
    );

    // One restoring step: shift the next dividend bit into the remainder.
    // A carry out of the remainder means the shifted value already exceeds
    // the divisor, and the ALU's 32-bit difference is still correct.
    logic [XLEN-1:0] shifted;
    logic            carry, take;

    assign shifted = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    assign carry   = rem_q[XLEN-1];
    assign take    = carry || !i_alu_slt;

    // Sign restoration for the selected result.
    logic [XLEN-1:0] fix_out;

    div_sign_fix #(.W(XLEN)) u_fix (
        .value  (is_rem_q ? rem_q : quo_q),
        .neg    (is_rem_q ? neg_r_q : neg_q_q),
        .result (fix_out)
    );

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/ALU outputs; ALU pins are idle outside ITER.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned and infers a latch.
        state_d        = state_q;
        o_ready        = 1'b0;
        o_busy         = 1'b1;
        o_valid        = 1'b0;
        o_alu_req      = 1'b0;
        o_alu_opsel    = 3'b000;
        o_alu_sub      = 1'b0;
        o_alu_unsigned = 1'b0;
        o_alu_arith    = 1'b0;
        o_alu_op1      = '0;
        o_alu_op2      = '0;
        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (accept) state_d = fast ? DONE : ITER;
            end
            ITER: begin
                o_alu_req      = 1'b1;
                o_alu_opsel    = ALU_OPSEL_ADD;
                o_alu_sub      = 1'b1;
                o_alu_unsigned = 1'b1;
                o_alu_op1      = shifted;
                o_alu_op2      = dsr_q;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            is_signed_q <= 1'b0;
            is_rem_q    <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_signed_q <= is_signed_in;
                        is_rem_q    <= is_rem_in;
                        if (fast) begin
                            result_q <= fast_result;
                        end else begin
                            quo_q   <= op1_mag;
                            dsr_q   <= op2_mag;
                            rem_q   <= '0;
                            cnt_q   <= CNT_W'(XLEN - 1);
                            neg_q_q <= is_signed_in && (i_op1[XLEN-1] ^ i_op2[XLEN-1]) && !div_zero;
                            neg_r_q <= is_signed_in && i_op1[XLEN-1];
                        end
                    end
                end
                ITER: begin
                    rem_q <= take ? i_alu_result : shifted;
                    quo_q <= {quo_q[XLEN-2:0], take};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    result_q <= fix_out;
                end
                default: ;
            endcase
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver pushes expected results and
// due cycles, a negedge monitor checks them when o_valid appears.
module tb_div_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [2:0]  i_func3 = 3'b000;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_op2 = '0;
    logic        o_ready, o_valid, o_busy, o_alu_req;
    logic [31:0] o_result;
    logic [2:0]  o_alu_opsel;
    logic        o_alu_sub, o_alu_unsigned, o_alu_arith;
    logic [31:0] o_alu_op1, o_alu_op2;
    logic [31:0] i_alu_result;
    logic        i_alu_slt;

    div_sequencer #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_flush        (i_flush),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_func3        (i_func3),
        .i_op1          (i_op1),
        .i_op2          (i_op2),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_result       (o_result),
        .o_busy         (o_busy),
        .o_alu_req      (o_alu_req),
        .o_alu_opsel    (o_alu_opsel),
        .o_alu_sub      (o_alu_sub),
        .o_alu_unsigned (o_alu_unsigned),
        .o_alu_arith    (o_alu_arith),
        .o_alu_op1      (o_alu_op1),
        .o_alu_op2      (o_alu_op2),
        .i_alu_result   (i_alu_result),
        .i_alu_slt      (i_alu_slt)
    );

    // Stand-in for the shared combinational execute ALU.
    always_comb begin
        i_alu_result = o_alu_sub ? (o_alu_op1 - o_alu_op2) : (o_alu_op1 + o_alu_op2);
        i_alu_slt    = (o_alu_op1 < o_alu_op2);
    end

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    bit   seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: checks value and arrival cycle on the first valid cycle,
    // retires the entry on the handshake.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check({sb[0].name, "_result"}, o_result, sb[0].res);
                    check({sb[0].name, "_cycle"}, 32'(cyc), 32'(sb[0].due));
                end
            end
            if (o_valid && i_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit expect_result,
                         input string name);
        int w = 0;
        @(negedge i_clk);
        while (!o_ready && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
        i_func3 = f3;
        i_op1   = a;
        i_op2   = b;
        i_valid = 1'b1;
        if (expect_result) sb.push_back('{res: exp, due: cyc + lat, name: name});
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        int vcount;
        int w;

        // Reset state.
        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_alu_req", 32'(o_alu_req), 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_alu_op1", o_alu_op1, 32'd0);
        check("rst_alu_sub", 32'(o_alu_sub), 32'd0);
        i_rst_n = 1'b1;

        // DIVU 100/7, probing ALU ownership in the first ITER cycle.
        issue(3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b1, "divu_100_7");
        @(negedge i_clk);
        check("iter_alu_req", 32'(o_alu_req), 32'd1);
        check("iter_alu_sub", 32'(o_alu_sub), 32'd1);
        check("iter_alu_unsigned", 32'(o_alu_unsigned), 32'd1);
        check("iter_alu_arith", 32'(o_alu_arith), 32'd0);
        check("iter_alu_opsel", 32'(o_alu_opsel), 32'd0);
        check("iter_alu_op2", o_alu_op2, 32'd7);
        check("iter_busy", 32'(o_busy), 32'd1);
        check("iter_ready", 32'(o_ready), 32'd0);
        wait_done();

        issue(3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b1, "remu_100_7");
        wait_done();
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1, "div_m7_2");
        wait_done();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1, "rem_m7_2");
        wait_done();
        issue(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b1, "divu_max_1");
        wait_done();
        issue(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, 1'b1, "remu_carry");
        wait_done();
        issue(3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b1, "rem_m100_7");
        wait_done();

        // Fast paths.
        issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, "divu_5_0");
        wait_done();
        issue(3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b1, "rem_5_0");
        wait_done();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1, "div_ovf");
        wait_done();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1, "rem_ovf");
        wait_done();

        // Flush in the 10th ITER cycle; nothing may come out.
        issue(3'b101, 32'd1000, 32'd3, 32'd0, 34, 1'b0, "flushed");
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        @(negedge i_clk);
        check("flush_ready", 32'(o_ready), 32'd1);
        check("flush_alu_req", 32'(o_alu_req), 32'd0);
        check("flush_busy", 32'(o_busy), 32'd0);
        vcount = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) vcount++;
        end
        check("flush_no_valid", 32'(vcount), 32'd0);
        issue(3'b101, 32'd9, 32'd3, 32'd3, 34, 1'b1, "divu_9_3");
        wait_done();

        // Backpressure: result holds, o_ready returns after the handshake.
        i_ready = 1'b0;
        issue(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 1'b1, "div_100_m7");
        w = 0;
        while (!o_valid && w < 100) begin
            @(negedge i_clk);
            w++;
        end
        check("bp_valid_seen", 32'(o_valid), 32'd1);
        repeat (3) begin
            @(posedge i_clk);
            @(negedge i_clk);
            check("bp_hold_valid", 32'(o_valid), 32'd1);
            check("bp_hold_result", o_result, 32'hFFFF_FFF2);
        end
        @(posedge i_clk);
        #1 i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_ready_in_handshake", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        check("bp_ready_after", 32'(o_ready), 32'd1);
        check("bp_valid_after", 32'(o_valid), 32'd0);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
